// File: rtl/fifo_pkg.sv
// Shared helpers for the flagged synchronous FIFO: pointer sizing and depth legality.
package fifo_pkg;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read.
module fifo_mem #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost/full/empty flags, sticky error flags
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 6,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_TH  = 6,
  parameter int unsigned AEMPTY_TH = 1,
  parameter int unsigned FWFT      = 0
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    write_enable,
  input  logic                    read_enable,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    clr_err,
  output logic [DATA_W-1:0]       data_o,
  output logic                    valid_o,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C  = cnt_t'(AFULL_TH);
  localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_TH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of 2 and >= 2");
  end

  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic full_q, empty_q, afull_q, aempty_q;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic rd_acc, wr_acc;
  logic [DATA_W-1:0] rdata;

  // A push into a full FIFO is only legal when a pop frees the slot on the same edge.
  assign rd_acc = read_enable & ~empty_q;
  assign wr_acc = write_enable & (~full_q | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + cnt_t'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - cnt_t'(1);
  end

  // A fresh error in the clearing cycle takes precedence over clr_err.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (write_enable && !wr_acc) ovf_d = 1'b1;
    if (read_enable && !rd_acc)  unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AFULL_C);
      aempty_q <= (count_d <= AEMPTY_C);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign data_o  = rdata;
    assign valid_o = ~empty_q;
  end else begin : g_std
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
      if (srst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) data_q <= rdata;
      end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
